// File: rtl/full_light_pkg.sv
// Shared types and widths for the parking-lot occupancy controller.
package full_light_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ALARM   = 2'd1,
    HOLDOFF = 2'd2
  } alarm_state_t;

  localparam int TIMER_W  = 8;
  localparam int REJECT_W = 16;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser plus previous-value flop with registered rising-edge output.
// All chain flops reset to 1 so a level already high at reset release gives no edge.
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic rise
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic rise_q, rise_d;

  always_comb begin
    sync1_d = sig_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    rise_d  = sync2_q & ~prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      rise_q  <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/full_light_ctrl.sv
// Occupancy counter with saturating reject counter and a stretched,
// hold-off-guarded full-light pulse raised when a car arrives at a full lot.
module full_light_ctrl
  import full_light_pkg::*;
#(
  parameter  int CAPACITY    = 15,
  parameter  int PULSE_LEN   = 4,
  parameter  int HOLDOFF_LEN = 2,
  localparam int COUNT_W     = $clog2(CAPACITY + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enter_sensor,
  input  logic                exit_sensor,
  input  logic                clr_reject,
  output logic [COUNT_W-1:0]  count,
  output logic                full,
  output logic                empty,
  output logic                full_pulse,
  output logic [REJECT_W-1:0] reject_cnt,
  output alarm_state_t        dbg_state
);

  localparam logic [TIMER_W-1:0] PULSE_RELOAD = TIMER_W'(PULSE_LEN - 1);
  localparam logic [TIMER_W-1:0] HOLD_RELOAD  =
    TIMER_W'((HOLDOFF_LEN == 0) ? 0 : HOLDOFF_LEN - 1);

  logic enter_rise, exit_rise;

  edge_sync u_enter_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (enter_sensor),
    .rise   (enter_rise)
  );

  edge_sync u_exit_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (exit_sensor),
    .rise   (exit_rise)
  );

  logic [COUNT_W-1:0]  count_q, count_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;
  logic [REJECT_W-1:0] reject_q, reject_d;
  alarm_state_t        state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                do_reject;

  // Simultaneous enter and exit edges cancel: no count change, no rejection.
  always_comb begin
    count_d   = count_q;
    do_reject = 1'b0;
    if (enter_rise && !exit_rise) begin
      if (!full_q) count_d = count_q + COUNT_W'(1);
      else         do_reject = 1'b1;
    end else if (exit_rise && !enter_rise && !empty_q) begin
      count_d = count_q - COUNT_W'(1);
    end
    full_d  = (count_d == COUNT_W'(CAPACITY));
    empty_d = (count_d == '0);
  end

  always_comb begin
    reject_d = reject_q;
    if (clr_reject)                        reject_d = '0;
    else if (do_reject && reject_q != '1)  reject_d = reject_q + REJECT_W'(1);
  end

  // A rejection during ALARM reloads the timer; during HOLDOFF it is only counted.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        if (do_reject) begin
          state_d = ALARM;
          timer_d = PULSE_RELOAD;
        end
      end
      ALARM: begin
        if (do_reject) begin
          timer_d = PULSE_RELOAD;
        end else if (timer_q == '0) begin
          if (HOLDOFF_LEN == 0) begin
            state_d = IDLE;
            timer_d = '0;
          end else begin
            state_d = HOLDOFF;
            timer_d = HOLD_RELOAD;
          end
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      HOLDOFF: begin
        if (timer_q == '0) state_d = IDLE;
        else               timer_d = timer_q - TIMER_W'(1);
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      reject_q <= '0;
      state_q  <= IDLE;
      timer_q  <= '0;
    end else begin
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      reject_q <= reject_d;
      state_q  <= state_d;
      timer_q  <= timer_d;
    end
  end

  assign count      = count_q;
  assign full       = full_q;
  assign empty      = empty_q;
  assign full_pulse = (state_q == ALARM);
  assign reject_cnt = reject_q;
  assign dbg_state  = state_q;

endmodule
